// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared bus widths, reset PC and fetch-stage state encoding
package cpu_defs;
  localparam int FS_TO_DS_BUS_W = 65;
  localparam int BR_BUS_W = 33;
  localparam int FLUSH_BUS_W = 33;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fs_state_e;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, single-outstanding inst_sram requests, redirect and stale-response handling
module fetch_stage
  import cpu_defs::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ds_allowin,
  input  logic [BR_BUS_W-1:0]       br_bus,
  input  logic [FLUSH_BUS_W-1:0]    ws_reflush_fs_bus,
  output logic                      fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [1:0]                inst_sram_size,
  output logic [31:0]               inst_sram_addr,
  output logic [3:0]                inst_sram_wstrb,
  output logic [31:0]               inst_sram_wdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata
);
  fs_state_e   state_q, state_d;
  logic [31:0] next_pc_q, next_pc_d, pc_q, pc_d, inst_buf_q, inst_buf_d;
  logic        adef_q, adef_d, discard_q, discard_d, redirect_pending_q, redirect_pending_d;
  logic        valid;
  logic        flush, redir;
  logic [31:0] target;
  assign flush = ws_reflush_fs_bus[32];
  assign redir = flush | br_bus[32];
  assign target = flush ? ws_reflush_fs_bus[31:0] : br_bus[31:0];
  assign inst_sram_wr = 1'b0;
  assign inst_sram_size = 2'b10;
  assign inst_sram_wstrb = 4'b0;
  assign inst_sram_wdata = 32'b0;
  // A request already on the bus keeps its address (parked in pc_q) until accepted, even after a redirect
  assign inst_sram_addr = redirect_pending_q ? pc_q : next_pc_q;
  assign inst_sram_req = (state_q == S_REQ) && !reset && (redirect_pending_q || next_pc_q[1:0] == 2'b00);
  assign fs_to_ds_valid = valid & ~flush;
  // Next-state, redirect and ID handshake logic
  always_comb begin
    state_d = state_q;
    next_pc_d = next_pc_q;
    pc_d = pc_q;
    inst_buf_d = inst_buf_q;
    adef_d = adef_q;
    discard_d = discard_q;
    redirect_pending_d = redirect_pending_q;
    valid = 1'b0;
    fs_to_ds_bus = {adef_q, inst_buf_q, pc_q};
    if (state_q == S_REQ) begin
      if (inst_sram_req && inst_sram_addr_ok) begin
        state_d = S_WAIT;
        pc_d = inst_sram_addr;
        discard_d = redir | redirect_pending_q;
        redirect_pending_d = 1'b0;
        if (redir) next_pc_d = target;
      end else if (redir) begin
        next_pc_d = target;
        if (inst_sram_req && !redirect_pending_q) begin
          redirect_pending_d = 1'b1;
          pc_d = next_pc_q;
        end
      end else if (!inst_sram_req) begin
        state_d = S_HOLD;
        adef_d = 1'b1;
        inst_buf_d = 32'b0;
        pc_d = next_pc_q;
      end
    end else if (state_q == S_WAIT) begin
      if (inst_sram_data_ok) begin
        state_d = S_REQ;
        discard_d = 1'b0;
        if (redir) next_pc_d = target;
        else if (discard_q) next_pc_d = next_pc_q;
        else if (ds_allowin) begin
          valid = 1'b1;
          fs_to_ds_bus = {1'b0, inst_sram_rdata, pc_q};
          next_pc_d = pc_q + 32'd4;
        end else begin
          state_d = S_HOLD;
          adef_d = 1'b0;
          inst_buf_d = inst_sram_rdata;
        end
      end else if (redir) begin
        discard_d = 1'b1;
        next_pc_d = target;
      end
    end else begin
      valid = ~redir;
      if (redir) begin
        state_d = S_REQ;
        next_pc_d = target;
      end else if (ds_allowin) begin
        state_d = S_REQ;
        next_pc_d = pc_q + 32'd4;
      end
    end
  end
  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      next_pc_q <= RESET_PC;
      pc_q <= 32'b0;
      inst_buf_q <= 32'b0;
      adef_q <= 1'b0;
      discard_q <= 1'b0;
      redirect_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      next_pc_q <= next_pc_d;
      pc_q <= pc_d;
      inst_buf_q <= inst_buf_d;
      adef_q <= adef_d;
      discard_q <= discard_d;
      redirect_pending_q <= redirect_pending_d;
    end
  end
endmodule
